// File: rtl/multich_sample_feeder_pkg.sv
// Shared defaults for the multichannel sample feeder and its FIFO.
// Channel count, sample width and FIFO depth common with the resampler.
package multich_sample_feeder_pkg;

    localparam int MSF_NUM_CH      = 2;
    localparam int MSF_NUM_CH_LOG2 = 1;
    localparam int MSF_WIDTH       = 24;
    localparam int MSF_DEPTH_LOG2  = 4;

    function automatic int depth_of(input int log2);
        return 1 << log2;
    endfunction

endpackage

// File: rtl/multich_sample_feeder_sample_fifo.sv
// sample_fifo: synchronous FIFO, registered rdata updated only on a served pop.
// Ports: clk, rst, push/wdata, pop -> rdata, count, full, empty.
module sample_fifo
    import multich_sample_feeder_pkg::*;
#(
    parameter int WIDTH      = MSF_WIDTH,
    parameter int DEPTH_LOG2 = MSF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = depth_of(DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] FULL_CNT =
        (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A full FIFO still accepts a push when a pop frees a slot at the same edge.
    assign push_ok = push && (!full || pop);
    // No bypass: a pop on an empty FIFO is never served by the concurrent push.
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rdata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/multich_sample_feeder.sv
// multich_sample_feeder: per-channel FIFOs answering resampler pops with a
// one-cycle ack; push_i/push_data_i in, pop_i -> ack_o/data_o, sticky flags out.
module multich_sample_feeder
    import multich_sample_feeder_pkg::*;
#(
    parameter int NUM_CH      = MSF_NUM_CH,
    parameter int NUM_CH_LOG2 = MSF_NUM_CH_LOG2,
    parameter int DEPTH_LOG2  = MSF_DEPTH_LOG2,
    parameter int WIDTH       = MSF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       push_i,
    input  logic [WIDTH*NUM_CH-1:0] push_data_i,
    output logic [NUM_CH-1:0]       full_o,
    input  logic [NUM_CH-1:0]       pop_i,
    output logic [NUM_CH-1:0]       ack_o,
    output logic [WIDTH*NUM_CH-1:0] data_o,
    output logic [NUM_CH-1:0]       underrun_o,
    output logic [NUM_CH-1:0]       overrun_o,
    input  logic                    clr_flags_i
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT =
        (DEPTH_LOG2 + 1)'(depth_of(DEPTH_LOG2));

    if (NUM_CH_LOG2 < 1 || NUM_CH > (1 << NUM_CH_LOG2)) begin : g_bad_cfg
        $error("NUM_CH_LOG2 too small for NUM_CH");
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [WIDTH-1:0]    rdata;
        logic [DEPTH_LOG2:0] count;
        logic                full;
        logic                empty;
        logic                ack_q;
        logic                zero_q;
        logic                under_q;
        logic                over_q;
        logic                set_under;
        logic                set_over;

        sample_fifo #(
            .WIDTH      (WIDTH),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_i[n]),
            .wdata (push_data_i[WIDTH*n +: WIDTH]),
            .pop   (pop_i[n]),
            .rdata (rdata),
            .count (count),
            .full  (full),
            .empty (empty)
        );

        assign set_under = pop_i[n] && empty;
        // A push into a full FIFO is only dropped if no pop frees a slot.
        assign set_over  = push_i[n] && full && !pop_i[n];

        always_ff @(posedge clk) begin
            if (rst) begin
                ack_q   <= 1'b0;
                zero_q  <= 1'b0;
                under_q <= 1'b0;
                over_q  <= 1'b0;
            end else begin
                ack_q <= pop_i[n];
                // zero_q selects silence until the next pop re-decides it.
                if (pop_i[n]) begin
                    zero_q <= empty;
                end
                if (set_under) begin
                    under_q <= 1'b1;
                end else if (clr_flags_i) begin
                    under_q <= 1'b0;
                end
                if (set_over) begin
                    over_q <= 1'b1;
                end else if (clr_flags_i) begin
                    over_q <= 1'b0;
                end
            end
        end

        assign ack_o[n]      = ack_q;
        assign underrun_o[n] = under_q;
        assign overrun_o[n]  = over_q;
        assign full_o[n]     = (count == FULL_CNT);
        assign data_o[WIDTH*n +: WIDTH] = zero_q ? '0 : rdata;
    end

endmodule

// File: tb/tb_multich_sample_feeder.sv
// Directed self-checking bench for multich_sample_feeder.
// Drives 1 ns after each rising edge, checks outputs at the same point.
module tb_multich_sample_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  push_i;
    logic [47:0] push_data_i;
    logic [1:0]  full_o;
    logic [1:0]  pop_i;
    logic [1:0]  ack_o;
    logic [47:0] data_o;
    logic [1:0]  underrun_o;
    logic [1:0]  overrun_o;
    logic        clr_flags_i;

    int n_cmp = 0;
    int n_err = 0;

    multich_sample_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .full_o      (full_o),
        .pop_i       (pop_i),
        .ack_o       (ack_o),
        .data_o      (data_o),
        .underrun_o  (underrun_o),
        .overrun_o   (overrun_o),
        .clr_flags_i (clr_flags_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        push_i      = 2'b00;
        push_data_i = '0;
        pop_i       = 2'b00;
        clr_flags_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();

        // 1: reset / idle state
        chk("rst_ack", 48'(ack_o), 48'(2'b00));
        chk("rst_data", data_o, 48'h0);
        chk("rst_under", 48'(underrun_o), 48'(2'b00));
        chk("rst_over", 48'(overrun_o), 48'(2'b00));
        chk("rst_full", 48'(full_o), 48'(2'b00));

        // 2: three pushes then three single pops on ch0
        for (int v = 1; v <= 3; v++) begin
            push_i      = 2'b01;
            push_data_i = {24'h0, 24'(v)};
            tick();
        end
        push_i = 2'b00;
        for (int v = 1; v <= 3; v++) begin
            pop_i = 2'b01;
            tick();
            chk("pop_ack", 48'(ack_o), 48'(2'b01));
            chk("pop_data", data_o, {24'h0, 24'(v)});
            pop_i = 2'b00;
            tick();
            chk("ack_drop", 48'(ack_o), 48'(2'b00));
        end
        chk("ch_under_none", 48'(underrun_o), 48'(2'b00));

        // 3: empty pop on ch1, then clear
        pop_i = 2'b10;
        tick();
        chk("ch1_ack", 48'(ack_o), 48'(2'b10));
        chk("ch1_data", data_o, {24'h0, 24'h3});
        chk("ch1_under", 48'(underrun_o), 48'(2'b10));
        pop_i       = 2'b00;
        clr_flags_i = 1'b1;
        tick();
        clr_flags_i = 1'b0;
        chk("clr_under", 48'(underrun_o), 48'(2'b00));

        // 4: overfill ch0, then drain in order
        for (int v = 1; v <= 17; v++) begin
            push_i      = 2'b01;
            push_data_i = {24'h0, 24'(v)};
            tick();
            if (v == 16) begin
                chk("full_at16", 48'(full_o), 48'(2'b01));
                chk("no_over16", 48'(overrun_o), 48'(2'b00));
            end
        end
        push_i = 2'b00;
        chk("over_17", 48'(overrun_o), 48'(2'b01));
        chk("full_17", 48'(full_o), 48'(2'b01));
        pop_i = 2'b01;
        for (int v = 1; v <= 16; v++) begin
            tick();
            chk("drain_ack", 48'(ack_o), 48'(2'b01));
            chk("drain_data", data_o, {24'h0, 24'(v)});
        end
        pop_i = 2'b00;
        tick();
        chk("drain_ack_end", 48'(ack_o), 48'(2'b00));
        chk("drain_full_end", 48'(full_o), 48'(2'b00));
        chk("drain_under", 48'(underrun_o), 48'(2'b00));
        clr_flags_i = 1'b1;
        tick();
        clr_flags_i = 1'b0;
        chk("clr_over", 48'(overrun_o), 48'(2'b00));

        // 5a: push+pop at full
        for (int v = 1; v <= 16; v++) begin
            push_i      = 2'b01;
            push_data_i = {24'h0, 24'('h100 + v)};
            tick();
        end
        push_data_i = {24'h0, 24'h200};
        pop_i       = 2'b01;
        tick();
        chk("pp_full_ack", 48'(ack_o), 48'(2'b01));
        chk("pp_full_data", data_o, {24'h0, 24'h101});
        chk("pp_full_full", 48'(full_o), 48'(2'b01));
        chk("pp_full_over", 48'(overrun_o), 48'(2'b00));
        push_i = 2'b00;
        for (int v = 2; v <= 16; v++) begin
            tick();
            chk("pp_drain", data_o, {24'h0, 24'('h100 + v)});
        end
        tick();
        chk("pp_last", data_o, {24'h0, 24'h200});
        pop_i = 2'b00;
        tick();
        chk("pp_empty_full", 48'(full_o), 48'(2'b00));
        chk("pp_no_under", 48'(underrun_o), 48'(2'b00));

        // 5b: push+pop at empty
        push_i      = 2'b01;
        push_data_i = {24'h0, 24'h333};
        pop_i       = 2'b01;
        tick();
        chk("pe_ack", 48'(ack_o), 48'(2'b01));
        chk("pe_data", data_o, 48'h0);
        chk("pe_under", 48'(underrun_o), 48'(2'b01));
        push_i = 2'b00;
        tick();
        chk("pe_next", data_o, {24'h0, 24'h333});
        pop_i = 2'b00;
        tick();
        chk("pe_sticky", 48'(underrun_o), 48'(2'b01));
        clr_flags_i = 1'b1;
        tick();
        clr_flags_i = 1'b0;

        // 6: resampler cadence then reset mid-stream
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 64; c++) begin
                push_i      = (c == 5) ? 2'b11 : 2'b00;
                push_data_i = {24'('h20 + p), 24'('h10 + p)};
                pop_i       = (c == 63) ? 2'b11 : 2'b00;
                tick();
                if (c == 63) begin
                    chk("cad_ack", 48'(ack_o), 48'(2'b11));
                    chk("cad_data", data_o,
                        {24'('h20 + p), 24'('h10 + p)});
                end
            end
        end
        pop_i       = 2'b00;
        push_i      = 2'b11;
        push_data_i = {24'h777, 24'h666};
        tick();
        tick();
        push_i = 2'b00;
        pop_i  = 2'b11;
        rst    = 1'b1;
        tick();
        chk("mid_rst_ack", 48'(ack_o), 48'(2'b00));
        chk("mid_rst_data", data_o, 48'h0);
        chk("mid_rst_under", 48'(underrun_o), 48'(2'b00));
        rst = 1'b0;
        tick();
        chk("post_rst_ack", 48'(ack_o), 48'(2'b11));
        chk("post_rst_data", data_o, 48'h0);
        chk("post_rst_under", 48'(underrun_o), 48'(2'b11));
        pop_i = 2'b00;
        tick();
        chk("post_rst_idle", 48'(ack_o), 48'(2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
